// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation engine: state layout,
// round constants, S-box, linear-layer rotations and the engine FSM encoding.
package ascon_pack;

  // x0 lives in element [0], x4 in element [4].
  typedef logic [4:0][63:0] type_state;

  localparam int unsigned NUM_ROUNDS_MAX = 12;

  localparam logic [7:0] round_constant [0:11] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  // Indexed by the bit column {x0,x1,x2,x3,x4}; result bit 4 goes back to x0.
  localparam logic [4:0] sbox [0:31] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  localparam int unsigned ROT_A [0:4] = '{19, 61, 1, 10, 7};
  localparam int unsigned ROT_B [0:4] = '{28, 39, 6, 17, 41};

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_DONE = 2'd2
  } type_fsm;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round (pC, pS, pL); bypass passes the state through.
module ascon_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] const_idx_i,
  input  logic       bypass_i,
  output type_state  state_o
);

  type_state  c_s;
  type_state  s_s;
  type_state  l_s;
  logic [4:0] col;
  logic [4:0] sb;

  always_comb begin
    c_s = state_i;
    if (const_idx_i < 4'd12) begin
      c_s[2][7:0] = state_i[2][7:0] ^ round_constant[const_idx_i];
    end

    s_s = '0;
    col = '0;
    sb  = '0;
    for (int b = 0; b < 64; b++) begin
      col = {c_s[0][b], c_s[1][b], c_s[2][b], c_s[3][b], c_s[4][b]};
      sb  = sbox[col];
      s_s[0][b] = sb[4];
      s_s[1][b] = sb[3];
      s_s[2][b] = sb[2];
      s_s[3][b] = sb[1];
      s_s[4][b] = sb[0];
    end

    l_s[0] = s_s[0] ^ rotr(s_s[0], ROT_A[0]) ^ rotr(s_s[0], ROT_B[0]);
    l_s[1] = s_s[1] ^ rotr(s_s[1], ROT_A[1]) ^ rotr(s_s[1], ROT_B[1]);
    l_s[2] = s_s[2] ^ rotr(s_s[2], ROT_A[2]) ^ rotr(s_s[2], ROT_B[2]);
    l_s[3] = s_s[3] ^ rotr(s_s[3], ROT_A[3]) ^ rotr(s_s[3], ROT_B[3]);
    l_s[4] = s_s[4] ^ rotr(s_s[4], ROT_A[4]) ^ rotr(s_s[4], ROT_B[4]);

    state_o = bypass_i ? state_i : l_s;
  end

endmodule

// File: rtl/ascon_permutation_engine.sv
// Multi-round ASCON permutation: R rounds (0..12) of p, UNROLL rounds per clock,
// result held in state_o and flagged by a one-cycle valid_o pulse.
module ascon_permutation_engine
  import ascon_pack::*;
#(
  parameter int UNROLL = 1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [3:0] rounds_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic       ready_o,
  output logic       valid_o,
  output type_fsm    fsm_o
);

  if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
    $error("ascon_permutation_engine: UNROLL must be within 1..4");
  end

  // Handshake: start_i is taken on any edge where ready_o=1 (not RUN); valid_o is
  // high for exactly the cycle after the edge that wrote a new state_o.
  type_fsm    fsm_q, fsm_d;
  logic [3:0] j_q, j_d;
  logic [3:0] rounds_q, rounds_d;
  type_state  work_q, work_d;
  type_state  res_q, res_d;

  logic       accept;
  logic       step_en;
  logic       last_step;
  logic [3:0] r_clamp;
  logic [3:0] r_cur;
  logic [3:0] j_cur;
  type_state  src;
  type_state  chain_out;

  assign accept  = start_i && (fsm_q != FSM_RUN);
  assign step_en = accept || (fsm_q == FSM_RUN);
  assign r_clamp = (rounds_i > 4'd12) ? 4'd12 : rounds_i;
  assign r_cur   = accept ? r_clamp : rounds_q;
  assign j_cur   = accept ? 4'd0 : j_q;
  assign src     = accept ? state_i : work_q;
  assign last_step = ({1'b0, j_cur} + 5'(UNROLL)) >= {1'b0, r_cur};

  // Stage s runs round j+s; stages past the last round just pass through.
  for (genvar s = 0; s < UNROLL; s++) begin : g_stage
    type_state  stage_in;
    type_state  stage_out;
    logic [3:0] idx;
    logic       byp;

    if (s == 0) begin : g_first
      assign stage_in = src;
    end else begin : g_next
      assign stage_in = g_stage[s-1].stage_out;
    end

    assign idx = 4'd12 - r_cur + j_cur + 4'(s);
    assign byp = ({1'b0, j_cur} + 5'(s)) >= {1'b0, r_cur};

    ascon_round u_round (
      .state_i     (stage_in),
      .const_idx_i (idx),
      .bypass_i    (byp),
      .state_o     (stage_out)
    );
  end

  assign chain_out = g_stage[UNROLL-1].stage_out;

  always_comb begin
    fsm_d    = fsm_q;
    j_d      = j_q;
    rounds_d = rounds_q;
    work_d   = work_q;
    res_d    = res_q;
    if (step_en) begin
      rounds_d = r_cur;
      if (last_step) begin
        fsm_d = FSM_DONE;
        res_d = chain_out;
        j_d   = 4'd0;
      end else begin
        fsm_d  = FSM_RUN;
        work_d = chain_out;
        j_d    = j_cur + 4'(UNROLL);
      end
    end else if (fsm_q == FSM_DONE) begin
      fsm_d = FSM_IDLE;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q    <= FSM_IDLE;
      j_q      <= '0;
      rounds_q <= '0;
      work_q   <= '0;
      res_q    <= '0;
    end else begin
      fsm_q    <= fsm_d;
      j_q      <= j_d;
      rounds_q <= rounds_d;
      work_q   <= work_d;
      res_q    <= res_d;
    end
  end

  assign state_o = res_q;
  assign ready_o = (fsm_q != FSM_RUN);
  assign valid_o = (fsm_q == FSM_DONE);
  assign fsm_o   = fsm_q;

endmodule

// File: tb/tb_ascon_permutation_engine.sv
// Bench for ascon_permutation_engine: four instances (UNROLL 1..4) share one
// stimulus stream and are checked every cycle against a round-by-round model.
module tb_ascon_permutation_engine;
  import ascon_pack::*;

  localparam logic [7:0] RC [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                     8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  localparam logic [4:0] SB [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                     5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                     5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                     5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam int RA [5] = '{19, 61, 1, 10, 7};
  localparam int RB [5] = '{28, 39, 6, 17, 41};

  logic       clock;
  logic       reset;
  logic       start;
  logic [3:0] rounds;
  type_state  state_in;

  type_state  st_o  [4];
  logic       vld_o [4];
  logic       rdy_o [4];
  type_fsm    fsm_o [4];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    ascon_permutation_engine #(.UNROLL(g + 1)) u_dut (
      .clock_i  (clock),
      .reset_i  (reset),
      .start_i  (start),
      .rounds_i (rounds),
      .state_i  (state_in),
      .state_o  (st_o[g]),
      .ready_o  (rdy_o[g]),
      .valid_o  (vld_o[g]),
      .fsm_o    (fsm_o[g])
    );
  end

  // Clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state model_perm(input type_state s_in, input int r);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  c;
    type_state   res;
    for (int w = 0; w < 5; w++) x[w] = s_in[w];
    for (int i = 0; i < r; i++) begin
      x[2] = x[2] ^ {56'd0, RC[12 - r + i]};
      for (int b = 0; b < 64; b++) begin
        c = SB[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        y[0][b] = c[4];
        y[1][b] = c[3];
        y[2][b] = c[2];
        y[3][b] = c[1];
        y[4][b] = c[0];
      end
      for (int w = 0; w < 5; w++) x[w] = y[w] ^ ror64(y[w], RA[w]) ^ ror64(y[w], RB[w]);
    end
    for (int w = 0; w < 5; w++) res[w] = x[w];
    return res;
  endfunction

  // Timing model: an accepted start at edge k finishes at edge k+N-1; the
  // engine is busy (ignores start) up to and including that edge.
  int        edge_n = 0;
  int        final_edge [4] = '{-1, -1, -1, -1};
  type_state pend   [4];
  type_state exp_st [4] = '{default: '0};
  logic      exp_vld[4] = '{default: 1'b0};
  logic      exp_rdy[4] = '{default: 1'b1};

  always @(posedge clock or posedge reset) begin
    int r;
    int n;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        final_edge[i] = -1;
        exp_st[i]     = '0;
        exp_vld[i]    = 1'b0;
        exp_rdy[i]    = 1'b1;
      end
    end else begin
      edge_n++;
      for (int i = 0; i < 4; i++) begin
        if (start && edge_n > final_edge[i]) begin
          r = (int'(rounds) > 12) ? 12 : int'(rounds);
          n = (r + i) / (i + 1);
          if (n < 1) n = 1;
          final_edge[i] = edge_n + n - 1;
          pend[i]       = model_perm(state_in, r);
        end
        exp_vld[i] = (edge_n == final_edge[i]);
        if (exp_vld[i]) exp_st[i] = pend[i];
        exp_rdy[i] = (edge_n >= final_edge[i]);
      end
    end
  end

  // Checking helpers
  task automatic check_vec(input string name, input int u, input logic [319:0] act,
                           input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s unroll=%0d got=%h want=%h", name, u, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int u, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s unroll=%0d got=%0d want=%0d", name, u, act, exp);
    end
  endtask

  int lat_seen [4];
  int vcount   [4] = '{0, 0, 0, 0};

  // Driver: one start pulse, then watch 16 cycles for each instance's valid.
  task automatic run_lat(input type_state s, input logic [3:0] r);
    @(negedge clock);
    start    = 1'b1;
    rounds   = r;
    state_in = s;
    for (int i = 0; i < 4; i++) lat_seen[i] = -1;
    for (int m = 0; m < 16; m++) begin
      @(negedge clock);
      start = 1'b0;
      for (int i = 0; i < 4; i++) if (vld_o[i] && lat_seen[i] < 0) lat_seen[i] = m;
    end
  endtask

  task automatic check_lat(input string name, input int e0, input int e1, input int e2,
                           input int e3);
    check_int(name, 1, lat_seen[0], e0);
    check_int(name, 2, lat_seen[1], e1);
    check_int(name, 3, lat_seen[2], e2);
    check_int(name, 4, lat_seen[3], e3);
  endtask

  task automatic check_all_state(input string name, input type_state exp);
    for (int i = 0; i < 4; i++) check_vec(name, i + 1, st_o[i], exp);
  endtask

  task automatic check_reset_vals();
    for (int i = 0; i < 4; i++) begin
      check_vec("rst_state", i + 1, st_o[i], '0);
      check_int("rst_valid", i + 1, int'(vld_o[i]), 0);
      check_int("rst_ready", i + 1, int'(rdy_o[i]), 1);
    end
  endtask

  type_state pat;
  type_state kat;
  type_state lit_r1;
  type_state sa;
  type_state sb_s;
  type_state sc;
  int        v_before;

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rounds   = '0;
    state_in = '0;

    pat    = {64'h0f1e2d3c4b5a6978, 64'h8899aabbccddeeff, 64'h0011223344556677,
              64'hfedcba9876543210, 64'h0123456789abcdef};
    kat    = '0;
    kat[0] = 64'h80400c0600000000;
    lit_r1 = {64'h0000000000000000, 64'h12E580000000004B, 64'h53FFFFFFFFFFFF90,
              64'h0000000096000213, 64'h000964B00000004B};
    sa     = {64'h1, 64'h2, 64'h3, 64'h4, 64'h5};
    sb_s   = {64'hdeadbeefdeadbeef, 64'h0, 64'hcafef00dcafef00d, 64'h0, 64'h1};
    sc     = {64'hffffffffffffffff, 64'h5555555555555555, 64'haaaaaaaaaaaaaaaa,
              64'h0f0f0f0f0f0f0f0f, 64'hf0f0f0f0f0f0f0f0};

    fork
      // Scoreboard: every cycle, all instances against the model.
      forever begin
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
          check_int("valid", i + 1, int'(vld_o[i]), int'(exp_vld[i]));
          check_int("ready", i + 1, int'(rdy_o[i]), int'(exp_rdy[i]));
          check_vec("state", i + 1, st_o[i], exp_st[i]);
          if (vld_o[i]) vcount[i]++;
        end
      end

      begin
        repeat (3) @(negedge clock);
        check_reset_vals();
        reset = 1'b0;

        // Pin the model to hand-derived values.
        check_vec("model_r0", 0, model_perm(pat, 0), pat);
        check_vec("model_r1_zero", 0, model_perm('0, 1), lit_r1);

        run_lat(pat, 4'd0);
        check_all_state("r0_passthrough", pat);
        check_lat("lat_r0", 0, 0, 0, 0);

        run_lat('0, 4'd1);
        check_all_state("r1_zero", lit_r1);
        check_lat("lat_r1", 0, 0, 0, 0);

        run_lat(kat, 4'd12);
        check_all_state("kat_p12", model_perm(kat, 12));
        check_lat("lat_r12", 11, 5, 3, 2);

        run_lat(kat, 4'd6);
        check_all_state("kat_p6", model_perm(kat, 6));
        check_lat("lat_r6", 5, 2, 1, 1);

        run_lat(kat, 4'd15);
        check_all_state("clamp_r15", model_perm(kat, 12));
        check_lat("lat_r15", 11, 5, 3, 2);

        // Start during RUN (edge k+3) is dropped by the slow instances; start at
        // the edge where UNROLL=1 sits in DONE (k+12) launches a new run.
        v_before = vcount[0];
        @(negedge clock);
        start = 1'b1; rounds = 4'd12; state_in = sa;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1; state_in = sb_s;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        check_int("b2b_valid_at_k11", 1, int'(vld_o[0]), 1);
        check_vec("b2b_first_result", 1, st_o[0], model_perm(sa, 12));
        start = 1'b1; rounds = 4'd8; state_in = sc;
        @(negedge clock);
        start = 1'b0;
        repeat (16) @(negedge clock);
        check_vec("b2b_second_result", 1, st_o[0], model_perm(sc, 8));
        check_int("b2b_valid_pulses", 1, vcount[0] - v_before, 2);

        // Asynchronous reset in the middle of a 12-round run.
        @(negedge clock);
        start = 1'b1; rounds = 4'd12; state_in = kat;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_vals();
        @(negedge clock);
        reset = 1'b0;
        run_lat(kat, 4'd12);
        check_all_state("restart_p12", model_perm(kat, 12));
        check_lat("lat_restart", 11, 5, 3, 2);
      end
    join_any

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
